// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// Round-robin arbiter that funnels N_REQ requesters onto a single APB master
// port. Each granted request runs as one SETUP + ACCESS transfer. Requests that
// target a slave index outside the PSEL range finish at once with an error
// response, and the bus stays idle.
//
// Optional feature: define APB_ARB_TIMEOUT_EN to abort an ACCESS phase that
// has waited TIMEOUT_CYCLES cycles without PREADY. The abort returns an error
// response. Without the macro no counter is built, and ACCESS waits
// indefinitely.
//
// Bus geometry comes from `D_ADDR_WIDTH, `D_DATA_WIDTH and `D_SLV_COUNT.
// Each macro is given a default here when the surrounding build does not set it.

`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif
`ifndef D_SLV_COUNT
`define D_SLV_COUNT 2
`endif

module apb_master_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ-1:0]                req_write,
  input  logic [N_REQ*`D_ADDR_WIDTH-1:0]  req_addr,
  input  logic [N_REQ*`D_DATA_WIDTH-1:0]  req_wdata,
  input  logic [N_REQ*8-1:0]              req_slv,
  output logic [N_REQ-1:0]                rsp_valid,
  output logic [`D_DATA_WIDTH-1:0]        rsp_rdata,
  output logic                            rsp_err,
  output logic [`D_ADDR_WIDTH-1:0]        PADDR,
  output logic                            PWRITE,
  output logic [`D_SLV_COUNT-1:0]         PSEL,
  output logic                            PENABLE,
  output logic [`D_DATA_WIDTH-1:0]        PWDATA,
  input  logic                            PREADY,
  input  logic [`D_DATA_WIDTH-1:0]        PRDATA
);

  localparam int AW    = `D_ADDR_WIDTH;
  localparam int DW    = `D_DATA_WIDTH;
  localparam int SC    = `D_SLV_COUNT;
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Round-robin pointer: the index searched first at the next grant.
  logic [IDX_W-1:0] rr_ptr;

  // Winner of the current arbitration round, along with its request fields.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [7:0]       win_slv;
  logic             win_slv_ok;

  // Request captured at grant time. These registers drive the bus for the
  // whole transfer.
  logic             lat_write;
  logic [AW-1:0]    lat_addr;
  logic [DW-1:0]    lat_wdata;
  logic [7:0]       lat_slv;
  logic [N_REQ-1:0] lat_owner;
  logic             latch_en;

  // Response registers, plus their next-cycle values.
  logic [N_REQ-1:0] rsp_valid_nxt;
  logic [DW-1:0]    rsp_rdata_nxt;
  logic             rsp_err_nxt;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
`endif

  // Search for the first active request, starting at rr_ptr and wrapping.
  always_comb begin
    int cand;
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % N_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign win_onehot = N_REQ'(1) << win_idx;
  assign win_slv    = req_slv[int'(win_idx)*8 +: 8];
  assign win_slv_ok = int'(win_slv) < SC;

`ifdef APB_ARB_TIMEOUT_EN
  // Count ACCESS cycles that pass without PREADY. Clear the count in every other case.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS && !PREADY && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values that were present before the edge.
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, grant strobe, bus drive and response next-values.
  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    latch_en      = 1'b0;
    rsp_valid_nxt = '0;
    rsp_rdata_nxt = '0;
    rsp_err_nxt   = 1'b0;
    PSEL          = '0;
    PENABLE       = 1'b0;
    PADDR         = '0;
    PWRITE        = 1'b0;
    PWDATA        = '0;

    case (state)
      IDLE: begin
        // Gating with PRESETn keeps req_ready low while reset is held, even
        // though the FSM already sits in IDLE during that time.
        if (win_found && PRESETn) begin
          req_ready = win_onehot;
          latch_en  = 1'b1;
          if (win_slv_ok) begin
            state_nxt = SETUP;
          end else begin
            // The slave index is outside the PSEL range. Answer with an error
            // and never touch the bus.
            rsp_valid_nxt = win_onehot;
            rsp_err_nxt   = 1'b1;
          end
        end
      end

      SETUP: begin
        PSEL      = SC'(1) << lat_slv;
        PADDR     = lat_addr;
        PWRITE    = lat_write;
        PWDATA    = lat_write ? lat_wdata : '0;
        state_nxt = ACCESS;
      end

      ACCESS: begin
        PSEL    = SC'(1) << lat_slv;
        PENABLE = 1'b1;
        PADDR   = lat_addr;
        PWRITE  = lat_write;
        PWDATA  = lat_write ? lat_wdata : '0;
        if (PREADY) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = lat_owner;
          rsp_rdata_nxt = lat_write ? '0 : PRDATA;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = lat_owner;
          rsp_err_nxt   = 1'b1;
        end
`endif
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture the winner's request fields and advance the round-robin pointer
  // whenever a grant is issued.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rr_ptr    <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_slv   <= '0;
      lat_owner <= '0;
    end else if (latch_en) begin
      rr_ptr    <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
      lat_write <= req_write[win_idx];
      lat_addr  <= req_addr[int'(win_idx)*AW +: AW];
      lat_wdata <= req_wdata[int'(win_idx)*DW +: DW];
      lat_slv   <= win_slv;
      lat_owner <= win_onehot;
    end
  end

  // Response outputs are registered and last one cycle. They are zero in every other cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed testbench for apb_master_arbiter. It uses N_REQ = 2, a 32-bit
// address and data bus, and 2 slaves. The timeout scenario follows
// APB_ARB_TIMEOUT_EN.

`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif
`ifndef D_SLV_COUNT
`define D_SLV_COUNT 2
`endif

module tb_apb_master_arbiter;

  localparam int N_REQ = 2;
  localparam int AW    = `D_ADDR_WIDTH;
  localparam int DW    = `D_DATA_WIDTH;
  localparam int SC    = `D_SLV_COUNT;

  logic                 PCLK = 1'b0;
  logic                 PRESETn;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ-1:0]     req_write;
  logic [N_REQ*AW-1:0]  req_addr;
  logic [N_REQ*DW-1:0]  req_wdata;
  logic [N_REQ*8-1:0]   req_slv;
  logic [N_REQ-1:0]     rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic [AW-1:0]        PADDR;
  logic                 PWRITE;
  logic [SC-1:0]        PSEL;
  logic                 PENABLE;
  logic [DW-1:0]        PWDATA;
  logic                 PREADY;
  logic [DW-1:0]        PRDATA;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 PCLK = ~PCLK;

  apb_master_arbiter #(
    .N_REQ          (N_REQ),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_slv   (req_slv),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA)
  );

  // Packed views of the bus and the response, so one comparison covers every field.
  typedef logic [SC+2+AW+DW-1:0] bus_t;
  typedef logic [N_REQ+1+DW-1:0] rsp_t;

  bus_t bus_act;
  rsp_t rsp_act;
  assign bus_act = {PSEL, PENABLE, PWRITE, PADDR, PWDATA};
  assign rsp_act = {rsp_valid, rsp_err, rsp_rdata};

  function automatic bus_t bus_exp(input logic [SC-1:0] sel, input logic en,
                                   input logic wr, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d);
    return {sel, en, wr, a, d};
  endfunction

  function automatic rsp_t rsp_exp(input logic [N_REQ-1:0] v, input logic e,
                                   input logic [DW-1:0] d);
    return {v, e, d};
  endfunction

  // Inputs change just after the rising edge. Outputs are sampled on the falling edge.
  task automatic drive_edge();
    @(posedge PCLK);
    #1;
  endtask

  task automatic sample();
    @(negedge PCLK);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [7:0] s);
    req_write[i]           = wr;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_slv[i*8 +: 8]      = s;
  endtask

  task automatic test_reset();
    #2;
    req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", req_ready); end
    n_cmp++; if (bus_act !== '0) begin n_fail++; $display("FAIL rst_bus: got %h want 0", bus_act); end
    n_cmp++; if (rsp_act !== '0) begin n_fail++; $display("FAIL rst_rsp: got %h want 0", rsp_act); end
    drive_edge();
    sample();
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready_edge: got %b want 00", req_ready); end
    drive_edge();
    PRESETn   = 1'b1;
    req_valid = 2'b00;
    sample();
    n_cmp++; if (bus_act !== '0) begin n_fail++; $display("FAIL rst_rel_bus: got %h want 0", bus_act); end
  endtask

  task automatic test_single_write();
    drive_edge();
    set_req(0, 1'b1, 32'h10, 32'hA5, 8'd1);
    req_valid = 2'b01;
    PREADY    = 1'b1;
    sample();
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL wr_grant: got %b want 01", req_ready); end
    n_cmp++; if (bus_act !== '0) begin n_fail++; $display("FAIL wr_c0_bus: got %h want 0", bus_act); end
    drive_edge();
    req_valid = 2'b00;
    sample();
    n_cmp++; if (bus_act !== bus_exp(2'b10, 1'b0, 1'b1, 32'h10, 32'hA5)) begin n_fail++; $display("FAIL wr_setup: got %h want %h", bus_act, bus_exp(2'b10, 1'b0, 1'b1, 32'h10, 32'hA5)); end
    n_cmp++; if (rsp_act !== '0) begin n_fail++; $display("FAIL wr_setup_rsp: got %h want 0", rsp_act); end
    drive_edge();
    sample();
    n_cmp++; if (bus_act !== bus_exp(2'b10, 1'b1, 1'b1, 32'h10, 32'hA5)) begin n_fail++; $display("FAIL wr_access: got %h want %h", bus_act, bus_exp(2'b10, 1'b1, 1'b1, 32'h10, 32'hA5)); end
    drive_edge();
    sample();
    n_cmp++; if (rsp_act !== rsp_exp(2'b01, 1'b0, '0)) begin n_fail++; $display("FAIL wr_rsp: got %h want %h", rsp_act, rsp_exp(2'b01, 1'b0, '0)); end
    n_cmp++; if (bus_act !== '0) begin n_fail++; $display("FAIL wr_idle_bus: got %h want 0", bus_act); end
    drive_edge();
    PREADY = 1'b0;
    sample();
    n_cmp++; if (rsp_act !== '0) begin n_fail++; $display("FAIL wr_rsp_once: got %h want 0", rsp_act); end
  endtask

  task automatic test_read_wait();
    PRDATA = 32'h5A;
    drive_edge();
    set_req(1, 1'b0, 32'h20, 32'h77, 8'd0);
    req_valid = 2'b10;
    PREADY    = 1'b0;
    sample();
    n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rd_grant: got %b want 10", req_ready); end
    drive_edge();
    req_valid = 2'b00;
    sample();
    n_cmp++; if (bus_act !== bus_exp(2'b01, 1'b0, 1'b0, 32'h20, '0)) begin n_fail++; $display("FAIL rd_setup: got %h want %h", bus_act, bus_exp(2'b01, 1'b0, 1'b0, 32'h20, '0)); end
    for (int k = 0; k < 4; k++) begin
      drive_edge();
      if (k == 3) PREADY = 1'b1;
      sample();
      n_cmp++; if (bus_act !== bus_exp(2'b01, 1'b1, 1'b0, 32'h20, '0)) begin n_fail++; $display("FAIL rd_access_%0d: got %h want %h", k, bus_act, bus_exp(2'b01, 1'b1, 1'b0, 32'h20, '0)); end
      n_cmp++; if (rsp_act !== '0) begin n_fail++; $display("FAIL rd_wait_rsp_%0d: got %h want 0", k, rsp_act); end
    end
    drive_edge();
    PREADY = 1'b0;
    sample();
    n_cmp++; if (rsp_act !== rsp_exp(2'b10, 1'b0, 32'h5A)) begin n_fail++; $display("FAIL rd_rsp: got %h want %h", rsp_act, rsp_exp(2'b10, 1'b0, 32'h5A)); end
    n_cmp++; if (bus_act !== '0) begin n_fail++; $display("FAIL rd_idle_bus: got %h want 0", bus_act); end
    drive_edge();
    sample();
    n_cmp++; if (rsp_act !== '0) begin n_fail++; $display("FAIL rd_rsp_once: got %h want 0", rsp_act); end
  endtask

  task automatic test_round_robin();
    logic [1:0] owner;
    logic [1:0] prev;
    set_req(0, 1'b1, 32'h100, 32'h11, 8'd0);
    set_req(1, 1'b0, 32'h200, 32'h33, 8'd1);
    PREADY = 1'b1;
    for (int c = 0; c < 12; c++) begin
      drive_edge();
      if (c == 0) req_valid = 2'b11;
      sample();
      owner = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
      prev  = (owner == 2'b01) ? 2'b10 : 2'b01;
      case (c % 3)
        0: begin
          n_cmp++; if (req_ready !== owner) begin n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", c / 3, req_ready, owner); end
          n_cmp++; if (bus_act !== '0) begin n_fail++; $display("FAIL rr_idle_bus_%0d: got %h want 0", c / 3, bus_act); end
          if (c > 0) begin
            n_cmp++; if (rsp_act !== rsp_exp(prev, 1'b0, (prev == 2'b10) ? 32'h5A : 32'h0)) begin n_fail++; $display("FAIL rr_rsp_%0d: got %h want %h", c / 3, rsp_act, rsp_exp(prev, 1'b0, (prev == 2'b10) ? 32'h5A : 32'h0)); end
          end
        end
        1: begin
          n_cmp++; if (bus_act !== ((owner == 2'b01) ? bus_exp(2'b01, 1'b0, 1'b1, 32'h100, 32'h11) : bus_exp(2'b10, 1'b0, 1'b0, 32'h200, '0))) begin n_fail++; $display("FAIL rr_setup_%0d: got %h", c / 3, bus_act); end
          n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rr_busy_ready_%0d: got %b want 00", c / 3, req_ready); end
        end
        default: begin
          n_cmp++; if (bus_act !== ((owner == 2'b01) ? bus_exp(2'b01, 1'b1, 1'b1, 32'h100, 32'h11) : bus_exp(2'b10, 1'b1, 1'b0, 32'h200, '0))) begin n_fail++; $display("FAIL rr_access_%0d: got %h", c / 3, bus_act); end
        end
      endcase
    end
    drive_edge();
    req_valid = 2'b00;
    sample();
    n_cmp++; if (rsp_act !== rsp_exp(2'b10, 1'b0, 32'h5A)) begin n_fail++; $display("FAIL rr_last_rsp: got %h want %h", rsp_act, rsp_exp(2'b10, 1'b0, 32'h5A)); end
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rr_no_grant: got %b want 00", req_ready); end
    drive_edge();
    PREADY = 1'b0;
    sample();
    n_cmp++; if (bus_act !== '0) begin n_fail++; $display("FAIL rr_quiet_bus: got %h want 0", bus_act); end
  endtask

  task automatic test_bad_slave();
    drive_edge();
    set_req(0, 1'b0, 32'h40, 32'h0, 8'hFF);
    req_valid = 2'b01;
    sample();
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bad_grant: got %b want 01", req_ready); end
    n_cmp++; if (bus_act !== '0) begin n_fail++; $display("FAIL bad_c0_bus: got %h want 0", bus_act); end
    drive_edge();
    req_valid = 2'b00;
    sample();
    n_cmp++; if (rsp_act !== rsp_exp(2'b01, 1'b1, '0)) begin n_fail++; $display("FAIL bad_rsp: got %h want %h", rsp_act, rsp_exp(2'b01, 1'b1, '0)); end
    n_cmp++; if (bus_act !== '0) begin n_fail++; $display("FAIL bad_c1_bus: got %h want 0", bus_act); end
    drive_edge();
    sample();
    n_cmp++; if (rsp_act !== '0) begin n_fail++; $display("FAIL bad_rsp_once: got %h want 0", rsp_act); end
    n_cmp++; if (bus_act !== '0) begin n_fail++; $display("FAIL bad_c2_bus: got %h want 0", bus_act); end
  endtask

  task automatic test_reset_mid();
    drive_edge();
    set_req(0, 1'b1, 32'h80, 32'hC3, 8'd1);
    req_valid = 2'b01;
    PREADY    = 1'b0;
    sample();
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rm_grant: got %b want 01", req_ready); end
    drive_edge();
    req_valid = 2'b00;
    sample();
    drive_edge();
    sample();
    n_cmp++; if (bus_act !== bus_exp(2'b10, 1'b1, 1'b1, 32'h80, 32'hC3)) begin n_fail++; $display("FAIL rm_access: got %h want %h", bus_act, bus_exp(2'b10, 1'b1, 1'b1, 32'h80, 32'hC3)); end
    #1;
    PRESETn   = 1'b0;
    req_valid = 2'b11;
    PREADY    = 1'b1;
    #1;
    n_cmp++; if (bus_act !== '0) begin n_fail++; $display("FAIL rm_async_bus: got %h want 0", bus_act); end
    n_cmp++; if (rsp_act !== '0) begin n_fail++; $display("FAIL rm_async_rsp: got %h want 0", rsp_act); end
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rm_async_ready: got %b want 00", req_ready); end
    drive_edge();
    sample();
    n_cmp++; if (rsp_act !== '0) begin n_fail++; $display("FAIL rm_held_rsp: got %h want 0", rsp_act); end
    drive_edge();
    PRESETn = 1'b1;
    set_req(1, 1'b0, 32'h90, 32'h0, 8'd0);
    sample();
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rm_prio0: got %b want 01", req_ready); end
    n_cmp++; if (rsp_act !== '0) begin n_fail++; $display("FAIL rm_rel_rsp: got %h want 0", rsp_act); end
    drive_edge();
    req_valid = 2'b00;
    sample();
    n_cmp++; if (bus_act !== bus_exp(2'b10, 1'b0, 1'b1, 32'h80, 32'hC3)) begin n_fail++; $display("FAIL rm_setup: got %h want %h", bus_act, bus_exp(2'b10, 1'b0, 1'b1, 32'h80, 32'hC3)); end
    drive_edge();
    sample();
    drive_edge();
    sample();
    n_cmp++; if (rsp_act !== rsp_exp(2'b01, 1'b0, '0)) begin n_fail++; $display("FAIL rm_rsp: got %h want %h", rsp_act, rsp_exp(2'b01, 1'b0, '0)); end
    drive_edge();
    PREADY = 1'b0;
    sample();
  endtask

  task automatic test_timeout();
    PRDATA = 32'h5A;
    drive_edge();
    set_req(1, 1'b0, 32'h44, 32'h99, 8'd0);
    req_valid = 2'b10;
    PREADY    = 1'b0;
    sample();
    n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL to_grant: got %b want 10", req_ready); end
    drive_edge();
    req_valid = 2'b00;
    sample();
`ifdef APB_ARB_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      drive_edge();
      sample();
      n_cmp++; if (bus_act !== bus_exp(2'b01, 1'b1, 1'b0, 32'h44, '0)) begin n_fail++; $display("FAIL to_access_%0d: got %h", k, bus_act); end
      n_cmp++; if (rsp_act !== '0) begin n_fail++; $display("FAIL to_wait_rsp_%0d: got %h want 0", k, rsp_act); end
    end
    drive_edge();
    sample();
    n_cmp++; if (bus_act !== '0) begin n_fail++; $display("FAIL to_abort_bus: got %h want 0", bus_act); end
    n_cmp++; if (rsp_act !== rsp_exp(2'b10, 1'b1, '0)) begin n_fail++; $display("FAIL to_abort_rsp: got %h want %h", rsp_act, rsp_exp(2'b10, 1'b1, '0)); end
    drive_edge();
    sample();
    n_cmp++; if (rsp_act !== '0) begin n_fail++; $display("FAIL to_rsp_once: got %h want 0", rsp_act); end
`else
    for (int k = 0; k < 100; k++) begin
      drive_edge();
      sample();
      n_cmp++; if (bus_act !== bus_exp(2'b01, 1'b1, 1'b0, 32'h44, '0)) begin n_fail++; $display("FAIL nto_access_%0d: got %h", k, bus_act); end
      n_cmp++; if (rsp_act !== '0) begin n_fail++; $display("FAIL nto_wait_rsp_%0d: got %h want 0", k, rsp_act); end
    end
    drive_edge();
    PREADY = 1'b1;
    sample();
    drive_edge();
    PREADY = 1'b0;
    sample();
    n_cmp++; if (rsp_act !== rsp_exp(2'b10, 1'b0, 32'h5A)) begin n_fail++; $display("FAIL nto_rsp: got %h want %h", rsp_act, rsp_exp(2'b10, 1'b0, 32'h5A)); end
    n_cmp++; if (bus_act !== '0) begin n_fail++; $display("FAIL nto_idle_bus: got %h want 0", bus_act); end
`endif
  endtask

  initial begin
    PRESETn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_slv   = '0;
    PREADY    = 1'b0;
    PRDATA    = '0;

    test_reset();
    test_single_write();
    test_read_wait();
    test_round_robin();
    test_bad_slave();
    test_reset_mid();
    test_timeout();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
